// File: rtl/sdram_arb.sv
// Arbiter sharing one SDRAM controller port between CPU, DMA and a refresh timer.
// Optional macro SDRAM_ARB_FAIR_EN lets DMA in after three consecutive CPU grants.
module sdram_arb #(
    parameter int unsigned AW          = 22,
    parameter int unsigned DW          = 16,
    parameter int unsigned SLOT        = 8,
    parameter int unsigned LATENCY     = 5,
    parameter int unsigned RFSH_PERIOD = 512
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ready,
    input  logic          cpuRf,
    input  logic          cpuRd,
    input  logic          cpuWr,
    input  logic [AW-1:0] cpuA,
    input  logic [DW-1:0] cpuD,
    output logic [DW-1:0] cpuQ,
    input  logic          dmaReq,
    input  logic          dmaWe,
    input  logic [AW-1:0] dmaA,
    input  logic [DW-1:0] dmaD,
    output logic          dmaAck,
    output logic [DW-1:0] dmaQ,
    output logic          sdrRf,
    output logic          sdrRd,
    output logic          sdrWr,
    output logic [AW-1:0] sdrA,
    output logic [DW-1:0] sdrD,
    input  logic [DW-1:0] sdrQ,
    output logic          busy
);

    localparam int unsigned CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned TW = $clog2(RFSH_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, CPU, RFSH, DMA} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_isRd;
    logic [TW-1:0] r_timer;

    logic          r_rfPrev, r_rdPrev, r_wrPrev;
    logic          r_pendRf, r_pendRd, r_pendWr;
    logic [AW-1:0] r_rdA, r_wrA;
    logic [DW-1:0] r_wrD;

    logic w_free, w_rfshDue, w_dmaFirst, w_capture;
    logic w_gntWr, w_gntRd, w_gntRf, w_gntDma;

    // The decision point is either idle or the last cycle of a slot, so slots run back to back.
    assign w_free    = (r_state == IDLE) || (r_cnt == CW'(SLOT - 1));
    assign w_rfshDue = r_pendRf || (r_timer >= TW'(RFSH_PERIOD));
    assign w_capture = ((r_state == CPU) || (r_state == DMA)) && r_isRd &&
                       (r_cnt == CW'(LATENCY - 1));

`ifdef SDRAM_ARB_FAIR_EN
    logic [1:0] r_fair;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fair <= 2'd0;
        end else if (w_gntDma || !dmaReq) begin
            r_fair <= 2'd0;
        end else if ((w_gntWr || w_gntRd) && (r_fair != 2'd3)) begin
            r_fair <= r_fair + 2'd1;
        end
    end

    assign w_dmaFirst = (r_fair == 2'd3) && dmaReq;
`else
    assign w_dmaFirst = 1'b0;
`endif

    always_comb begin
        w_gntWr  = 1'b0;
        w_gntRd  = 1'b0;
        w_gntRf  = 1'b0;
        w_gntDma = 1'b0;
        if (w_free && ready) begin
            if (w_dmaFirst) begin
                if (w_rfshDue) w_gntRf  = 1'b1;
                else           w_gntDma = 1'b1;
            end else if (r_pendWr) begin
                w_gntWr = 1'b1;
            end else if (r_pendRd) begin
                w_gntRd = 1'b1;
            end else if (w_rfshDue) begin
                w_gntRf = 1'b1;
            end else if (dmaReq) begin
                w_gntDma = 1'b1;
            end
        end
    end

    // CPU strobes are levels: only a rising edge creates a request; a grant consumes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rfPrev <= 1'b0;
            r_rdPrev <= 1'b0;
            r_wrPrev <= 1'b0;
            r_pendRf <= 1'b0;
            r_pendRd <= 1'b0;
            r_pendWr <= 1'b0;
            r_rdA    <= '0;
            r_wrA    <= '0;
            r_wrD    <= '0;
            r_timer  <= '0;
        end else begin
            r_rfPrev <= cpuRf;
            r_rdPrev <= cpuRd;
            r_wrPrev <= cpuWr;
            if (w_gntWr) r_pendWr <= 1'b0;
            if (w_gntRd) r_pendRd <= 1'b0;
            if (w_gntRf) r_pendRf <= 1'b0;
            if (cpuWr && !r_wrPrev) begin
                r_pendWr <= 1'b1;
                r_wrA    <= cpuA;
                r_wrD    <= cpuD;
            end
            if (cpuRd && !r_rdPrev) begin
                r_pendRd <= 1'b1;
                r_rdA    <= cpuA;
            end
            if (cpuRf && !r_rfPrev) r_pendRf <= 1'b1;
            if (w_gntRf) begin
                r_timer <= '0;
            end else if (ready && (r_timer < TW'(RFSH_PERIOD))) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_isRd  <= 1'b0;
            sdrRf   <= 1'b1;
            sdrRd   <= 1'b1;
            sdrWr   <= 1'b1;
            sdrA    <= '0;
            sdrD    <= '0;
            cpuQ    <= '0;
            dmaQ    <= '0;
            dmaAck  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            sdrRf  <= 1'b1;
            sdrRd  <= 1'b1;
            sdrWr  <= 1'b1;
            dmaAck <= 1'b0;
            if (w_capture) begin
                if (r_state == DMA) begin
                    dmaQ   <= sdrQ;
                    dmaAck <= 1'b1;
                end else begin
                    cpuQ <= sdrQ;
                end
            end
            if (w_gntWr || w_gntRd || w_gntRf || w_gntDma) begin
                r_cnt <= '0;
                busy  <= 1'b1;
                if (w_gntWr) begin
                    r_state <= CPU;
                    r_isRd  <= 1'b0;
                    sdrWr   <= 1'b0;
                    sdrA    <= r_wrA;
                    sdrD    <= r_wrD;
                end else if (w_gntRd) begin
                    r_state <= CPU;
                    r_isRd  <= 1'b1;
                    sdrRd   <= 1'b0;
                    sdrA    <= r_rdA;
                end else if (w_gntRf) begin
                    r_state <= RFSH;
                    r_isRd  <= 1'b0;
                    sdrRf   <= 1'b0;
                end else begin
                    r_state <= DMA;
                    r_isRd  <= !dmaWe;
                    sdrA    <= dmaA;
                    if (dmaWe) begin
                        sdrWr  <= 1'b0;
                        sdrD   <= dmaD;
                        dmaAck <= 1'b1;
                    end else begin
                        sdrRd <= 1'b0;
                    end
                end
            end else if (r_state != IDLE) begin
                if (r_cnt == CW'(SLOT - 1)) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed scenarios plus randomized traffic against
// a cycle-numbered reference model of the arbitration rules.
module tb_sdram_arb;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned SLOT = 8;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned RFSH = 512;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          cpuRf = 1'b0, cpuRd = 1'b0, cpuWr = 1'b0;
    logic [AW-1:0] cpuA = '0, dmaA = '0, sdrA;
    logic [DW-1:0] cpuD = '0, dmaD = '0, sdrQ = '0, cpuQ, dmaQ, sdrD;
    logic          dmaReq = 1'b0, dmaWe = 1'b0;
    logic          dmaAck, sdrRf, sdrRd, sdrWr, busy;

    sdram_arb #(
        .AW(AW), .DW(DW), .SLOT(SLOT), .LATENCY(LATENCY), .RFSH_PERIOD(RFSH)
    ) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .cpuRf(cpuRf), .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
        .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaA(dmaA), .dmaD(dmaD), .dmaAck(dmaAck), .dmaQ(dmaQ),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Time is measured in clock-edge numbers since reset: a grant at edge g owns edges
    // g..g+SLOT-1, the next decision may happen at edge g+SLOT, read data is taken at g+LATENCY.
    typedef struct {
        int unsigned at;
        bit          dma;
    } cap_t;

    cap_t          capq[$];
    int unsigned   m_edge = 0, m_free_at = 0, m_timer = 0;
    bit            m_pwr = 0, m_prd = 0, m_prf = 0;
    bit            pv_wr = 0, pv_rd = 0, pv_rf = 0;
    logic [AW-1:0] m_wrA = '0, m_rdA = '0;
    logic [DW-1:0] m_wrD = '0;
    int            m_fair = 0;
    logic          e_rf = 1, e_rd = 1, e_wr = 1, e_ack = 0, e_busy = 0;
    logic [AW-1:0] e_A = '0;
    logic [DW-1:0] e_D = '0, e_cpuQ = '0, e_dmaQ = '0;

    initial forever begin
        int g;
        bit due;
        bit dma_first;
        @(posedge clock or posedge reset);
        if (reset) begin
            m_edge = 0; m_free_at = 0; m_timer = 0; m_fair = 0;
            m_pwr = 0; m_prd = 0; m_prf = 0; pv_wr = 0; pv_rd = 0; pv_rf = 0;
            m_wrA = '0; m_rdA = '0; m_wrD = '0;
            e_rf = 1; e_rd = 1; e_wr = 1; e_ack = 0; e_busy = 0;
            e_A = '0; e_D = '0; e_cpuQ = '0; e_dmaQ = '0;
            capq.delete();
        end else begin
            m_edge++;
            e_rf = 1; e_rd = 1; e_wr = 1; e_ack = 0;
            if (capq.size() > 0 && capq[0].at == m_edge) begin
                if (capq[0].dma) begin
                    e_dmaQ = sdrQ;
                    e_ack  = 1;
                end else begin
                    e_cpuQ = sdrQ;
                end
                void'(capq.pop_front());
            end
            due = m_prf || (m_timer >= RFSH);
            dma_first = 0;
`ifdef SDRAM_ARB_FAIR_EN
            dma_first = (m_fair >= 3) && dmaReq;
`endif
            g = 0;  // 1 wr, 2 rd, 3 refresh, 4 dma
            if (ready && m_edge >= m_free_at) begin
                if (dma_first) g = due ? 3 : 4;
                else if (m_pwr) g = 1;
                else if (m_prd) g = 2;
                else if (due) g = 3;
                else if (dmaReq) g = 4;
            end
            case (g)
                1: begin e_wr = 0; e_A = m_wrA; e_D = m_wrD; m_pwr = 0; end
                2: begin
                    e_rd = 0; e_A = m_rdA; m_prd = 0;
                    capq.push_back('{at: m_edge + LATENCY, dma: 1'b0});
                end
                3: begin e_rf = 0; m_prf = 0; end
                4: begin
                    e_A = dmaA;
                    if (dmaWe) begin
                        e_wr = 0; e_D = dmaD; e_ack = 1;
                    end else begin
                        e_rd = 0;
                        capq.push_back('{at: m_edge + LATENCY, dma: 1'b1});
                    end
                end
                default: ;
            endcase
            if (g != 0) m_free_at = m_edge + SLOT;
            e_busy = (m_edge < m_free_at);
            if (g == 3) m_timer = 0;
            else if (ready && m_timer < RFSH) m_timer++;
            if (g == 4 || !dmaReq) m_fair = 0;
            else if ((g == 1 || g == 2) && m_fair < 3) m_fair++;
            if (cpuWr && !pv_wr) begin m_pwr = 1; m_wrA = cpuA; m_wrD = cpuD; end
            if (cpuRd && !pv_rd) begin m_prd = 1; m_rdA = cpuA; end
            if (cpuRf && !pv_rf) m_prf = 1;
            pv_wr = cpuWr; pv_rd = cpuRd; pv_rf = cpuRf;
        end
    end

    // Every cycle out of reset the DUT must agree with the model.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("model strobes", 64'({sdrRf, sdrRd, sdrWr}), 64'({e_rf, e_rd, e_wr}));
            check("model ack/busy", 64'({dmaAck, busy}), 64'({e_ack, e_busy}));
            check("model sdrA", 64'(sdrA), 64'(e_A));
            check("model sdrD", 64'(sdrD), 64'(e_D));
            check("model cpuQ", 64'(cpuQ), 64'(e_cpuQ));
            check("model dmaQ", 64'(dmaQ), 64'(e_dmaQ));
        end
    end

    // which: 0 rd strobe, 1 wr strobe, 2 rf strobe, 3 dmaAck, 4 any CPU-type strobe
    task automatic wait_ev(input int which, input int bound, output int cycles, output bit found);
        found  = 0;
        cycles = bound;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if ((which == 0 && !sdrRd) || (which == 1 && !sdrWr) || (which == 2 && !sdrRf) ||
                (which == 3 && dmaAck) || (which == 4 && (!sdrRd || !sdrWr))) begin
                found  = 1;
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;
        int  busy_cnt, low_cnt, acks;
        logic [DW-1:0] q4, q5;
        bit  ack_seen;

        repeat (3) @(negedge clock);
        check("reset strobes", 64'({sdrRf, sdrRd, sdrWr}), 64'(3'b111));
        check("reset ack/busy", 64'({dmaAck, busy}), 64'(2'b00));
        check("reset sdrA/sdrD", 64'({sdrA, sdrD}), 64'(0));
        check("reset cpuQ/dmaQ", 64'({cpuQ, dmaQ}), 64'(0));
        #1 reset = 0; ready = 1;

        // CPU read, constant read data
        @(negedge clock); #1;
        sdrQ = 16'h1234; cpuA = 22'h00ABCD; cpuRd = 1;
        wait_ev(0, 20, cyc, found);
        check("T1 read strobe seen", 64'(found), 64'(1));
        check("T1 sdrA", 64'(sdrA), 64'(22'h00ABCD));
        busy_cnt = busy ? 1 : 0;
        low_cnt = 1;
        q4 = '0; q5 = '0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clock);
            busy_cnt += busy ? 1 : 0;
            low_cnt += sdrRd ? 0 : 1;
            if (k == 4) q4 = cpuQ;
            if (k == 5) q5 = cpuQ;
        end
        check("T1 busy cycles", 64'(busy_cnt), 64'(8));
        check("T1 read strobe cycles", 64'(low_cnt), 64'(1));
        check("T1 cpuQ before latency", 64'(q4), 64'(0));
        check("T1 cpuQ at latency", 64'(q5), 64'(16'h1234));
        #1 cpuRd = 0;
        repeat (4) @(negedge clock);

        // Simultaneous write and read: write first, read one slot later
        #1 cpuA = 22'h000155; cpuD = 16'h5A5A; cpuWr = 1; cpuRd = 1;
        wait_ev(4, 20, cyc, found);
        check("T2 first strobe seen", 64'(found), 64'(1));
        check("T2 write first", 64'({sdrWr, sdrRd}), 64'(2'b01));
        check("T2 write data", 64'(sdrD), 64'(16'h5A5A));
        wait_ev(0, 20, cyc, found);
        check("T2 read gap", 64'(cyc + 1), 64'(8));
        #1 cpuWr = 0; cpuRd = 0;
        repeat (10) @(negedge clock);

        // DMA read, request kept high past the ack
        #1 sdrQ = 16'hBEEF; dmaWe = 0; dmaA = 22'h3FFFFF; dmaReq = 1;
        wait_ev(0, 20, cyc, found);
        check("T3 dma read strobe", 64'(found), 64'(1));
        check("T3 sdrA", 64'(sdrA), 64'(22'h3FFFFF));
        wait_ev(3, 20, cyc, found);
        check("T3 ack latency", 64'(cyc + 1), 64'(LATENCY));
        check("T3 dmaQ", 64'(dmaQ), 64'(16'hBEEF));
        @(negedge clock);
        check("T3 ack single pulse", 64'(dmaAck), 64'(0));
        wait_ev(0, 20, cyc, found);
        check("T3 second read", 64'(found), 64'(1));
        wait_ev(3, 20, cyc, found);
        check("T3 second ack", 64'(found), 64'(1));
        #1 dmaReq = 0;
        repeat (10) @(negedge clock);

        // Reset asserted during a DMA write grant cycle
        #1 dmaWe = 1; dmaA = 22'h2AAAA; dmaD = 16'hC3C3; dmaReq = 1;
        wait_ev(1, 20, cyc, found);
        check("T5 write grant seen", 64'(found), 64'(1));
        check("T5 write ack in grant", 64'(dmaAck), 64'(1));
        #1 reset = 1; dmaReq = 0;
        #1;
        check("T5 strobes after reset", 64'({sdrRf, sdrRd, sdrWr}), 64'(3'b111));
        check("T5 ack/busy after reset", 64'({dmaAck, busy}), 64'(2'b00));
        @(negedge clock); #1 reset = 0;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 0) check("T5 idle after reset", 64'(busy), 64'(0));
            acks += dmaAck ? 1 : 0;
        end
        check("T5 no ack after reset", 64'(acks), 64'(0));

        // Timer refresh, then a CPU refresh restarts the timer
        wait_ev(2, 600, cyc, found);
        check("T4 auto refresh timing", 64'(found && (cyc + 12 >= 504) && (cyc + 12 <= 520)),
              64'(1));
        repeat (100) @(negedge clock);
        #1 cpuRf = 1;
        wait_ev(2, 10, cyc, found);
        check("T4 cpu refresh prompt", 64'(found && cyc <= 3), 64'(1));
        #1 cpuRf = 0;
        wait_ev(2, 600, cyc, found);
        check("T4 timer restarted", 64'(found && (cyc >= 504) && (cyc <= 520)), 64'(1));

        // Randomized traffic; the DMA side obeys the request/ack handshake
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            ack_seen = dmaAck;
            #1;
            sdrQ = DW'($urandom);
            cpuA = AW'($urandom);
            cpuD = DW'($urandom);
            if ($urandom_range(0, 15) == 0) cpuRd = !cpuRd;
            if ($urandom_range(0, 15) == 0) cpuWr = !cpuWr;
            if ($urandom_range(0, 31) == 0) cpuRf = !cpuRf;
            if ($urandom_range(0, 99) == 0) ready = !ready;
            if (dmaReq && ack_seen) begin
                dmaReq = 1'($urandom_range(0, 1));
                dmaWe = 1'($urandom_range(0, 1));
                dmaA = AW'($urandom);
                dmaD = DW'($urandom);
            end else if (!dmaReq && $urandom_range(0, 3) == 0) begin
                dmaReq = 1;
                dmaWe = 1'($urandom_range(0, 1));
                dmaA = AW'($urandom);
                dmaD = DW'($urandom);
            end
        end
        repeat (20) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
